// File: rtl/mux_nto1_stream_if.sv
// Stream bundle for the N:1 multiplexer: N producer channels in, one consumer out.
// slave is the mux side; master is the producer/consumer side.
interface mux_nto1_stream_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = (N > 1) ? $clog2(N) : 1
);
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [WIDTH-1:0]   y;
  logic               y_valid;
  logic               y_ready;
  logic [SELW-1:0]    y_ch;

  modport slave (
    input  in_data, in_valid, y_ready,
    output in_ready, y, y_valid, y_ch
  );

  modport master (
    output in_data, in_valid, y_ready,
    input  in_ready, y, y_valid, y_ch
  );
endinterface

// File: rtl/mux_nto1_stream.sv
// N:1 valid/ready stream mux with a one-entry output register.
// Fixed-priority, round-robin and forced-select arbitration.
module mux_nto1_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic [1:0] mode,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] se,
  mux_nto1_stream_if.slave bus
);

  localparam int SELW = (N > 1) ? $clog2(N) : 1;

  logic [WIDTH-1:0] y_q, y_d;
  logic             vld_q, vld_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic [SELW-1:0]  ptr_q, ptr_d;

  logic             gnt_vld;
  logic [SELW-1:0]  gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  logic             space;
  logic             load;

  assign space = !vld_q || bus.y_ready;
  assign load  = !rst && en && space && gnt_vld;

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    unique case (1'b1)
      (mode == 2'b01): begin
        // Scan from ptr downwards so the final hit is the nearest one.
        for (int k = N - 1; k >= 0; k--) begin
          int j;
          logic [SELW-1:0] jj;
          j = int'(ptr_q) + k;
          if (j >= N) j = j - N;
          jj = SELW'(j);
          if (bus.in_valid[jj]) begin
            gnt_vld = 1'b1;
            gnt_idx = jj;
          end
        end
      end
      (mode == 2'b10): begin
        if (int'(se) < N) begin
          if (bus.in_valid[se]) begin
            gnt_vld = 1'b1;
            gnt_idx = se;
          end
        end
      end
      default: begin
        for (int k = N - 1; k >= 0; k--) begin
          if (bus.in_valid[k]) begin
            gnt_vld = 1'b1;
            gnt_idx = SELW'(k);
          end
        end
      end
    endcase
  end

  always_comb begin
    gnt_data     = '0;
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt_idx == SELW'(i)) begin
        gnt_data        = bus.in_data[i*WIDTH +: WIDTH];
        bus.in_ready[i] = load;
      end
    end
  end

  always_comb begin
    y_d   = y_q;
    ch_d  = ch_q;
    vld_d = vld_q;
    ptr_d = ptr_q;
    if (load) begin
      y_d   = gnt_data;
      ch_d  = gnt_idx;
      vld_d = 1'b1;
      if (mode == 2'b01)
        ptr_d = (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end else if (bus.y_ready) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q   <= '0;
      vld_q <= 1'b0;
      ch_q  <= '0;
      ptr_q <= '0;
    end else begin
      y_q   <= y_d;
      vld_q <= vld_d;
      ch_q  <= ch_d;
      ptr_q <= ptr_d;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = vld_q;
  assign bus.y_ch    = ch_q;

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Directed bench for mux_nto1_stream, N=4, WIDTH=8.
// Channel i always presents data 8'hA0+i.
module tb_mux_nto1_stream;

  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  logic [1:0] mode = 2'b00;
  logic [SELW-1:0] se = '0;

  int errs = 0;
  int checks = 0;

  mux_nto1_stream_if #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) bus ();

  mux_nto1_stream #(.WIDTH(WIDTH), .N(N)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .mode (mode),
    .se   (se),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic out(input string tag, input logic v,
                     input logic [7:0] d, input logic [1:0] c);
    chk({tag, ".vld"}, 32'(bus.y_valid), 32'(v));
    chk({tag, ".y"},   32'(bus.y),       32'(d));
    chk({tag, ".ch"},  32'(bus.y_ch),    32'(c));
  endtask

  task automatic rdy(input string tag, input logic [3:0] exp);
    #1;
    chk({tag, ".rdy"}, 32'(bus.in_ready), 32'(exp));
  endtask

  initial begin
    bus.in_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    bus.in_valid = '0;
    bus.y_ready  = 1'b1;
    tick();
    tick();
    rdy("rst_hold", 4'b0000);
    out("rst_hold", 1'b0, 8'h00, 2'd0);
    rst = 1'b0;
    tick();
    out("post_rst", 1'b0, 8'h00, 2'd0);

    // fixed priority
    bus.in_valid = 4'b1010;
    rdy("fix1", 4'b0010);
    tick();
    out("fix1", 1'b1, 8'hA1, 2'd1);
    bus.in_valid = 4'b1000;
    rdy("fix2", 4'b1000);
    tick();
    out("fix2", 1'b1, 8'hA3, 2'd3);
    bus.in_valid = 4'b0000;
    tick();
    chk("fix_drain.vld", 32'(bus.y_valid), 32'd0);

    // round-robin, continuous
    mode = 2'b01;
    bus.in_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] c;
      c = 2'(k % 4);
      rdy($sformatf("rr%0d", k), 4'b0001 << c);
      tick();
      out($sformatf("rr%0d", k), 1'b1, 8'hA0 + 8'(c), c);
    end
    bus.in_valid = 4'b0000;
    tick();
    chk("rr_drain.vld", 32'(bus.y_valid), 32'd0);

    // forced select
    mode = 2'b10;
    se = 2'd2;
    bus.in_valid = 4'b1111;
    rdy("frc1", 4'b0100);
    tick();
    out("frc1", 1'b1, 8'hA2, 2'd2);
    bus.in_valid = 4'b1011;
    rdy("frc2", 4'b0000);
    tick();
    out("frc2", 1'b0, 8'hA2, 2'd2);

    // backpressure
    mode = 2'b00;
    bus.in_valid = 4'b0001;
    tick();
    out("bp_load", 1'b1, 8'hA0, 2'd0);
    bus.y_ready = 1'b0;
    bus.in_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      rdy($sformatf("bp%0d", k), 4'b0000);
      tick();
      out($sformatf("bp%0d", k), 1'b1, 8'hA0, 2'd0);
    end
    bus.y_ready = 1'b1;
    rdy("bp_rel", 4'b0010);
    tick();
    out("bp_rel", 1'b1, 8'hA1, 2'd1);
    bus.in_valid = 4'b0000;
    tick();
    chk("bp_drain.vld", 32'(bus.y_valid), 32'd0);

    // enable; ch1 taken in rr so ptr becomes 2
    mode = 2'b01;
    bus.in_valid = 4'b0010;
    tick();
    out("en_pre", 1'b1, 8'hA1, 2'd1);
    en = 1'b0;
    bus.in_valid = 4'b1111;
    rdy("en_off", 4'b0000);
    tick();
    out("en_off1", 1'b0, 8'hA1, 2'd1);
    tick();
    chk("en_off2.vld", 32'(bus.y_valid), 32'd0);
    en = 1'b1;
    rdy("en_on", 4'b0100);
    tick();
    out("en_on", 1'b1, 8'hA2, 2'd2);

    // async reset mid-stream with a held word; ptr is now 3
    bus.y_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    out("rst_mid", 1'b0, 8'h00, 2'd0);
    chk("rst_mid.rdy", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    bus.y_ready = 1'b1;
    rdy("rst_ptr", 4'b0001);
    tick();
    out("rst_ptr", 1'b1, 8'hA0, 2'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
